dma_read_engine: RTL and testbench

DMA_READ_ENGINE -- requirements
Module: dma_read_engine

---
 rtl/dma_read_engine.sv | 183 ++++++++++++++++++
 tb/tb_dma_read_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_read_engine.sv
// dma_read_engine: single-outstanding AXI read master that streams a
// contiguous transfer of num_beats beats into an output FIFO. Bursts are
// split at MAX_BURST and at 4 KB boundaries, and an AR is only issued once
// the FIFO has room for the whole burst, so R beats are never back-pressured
// by a full buffer in normal operation.
module dma_read_engine #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [31:0]           num_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  err_rlast,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rlast,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int BPB = DATA_WIDTH / 8;
  localparam int LB  = $clog2(BPB);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(MAX_BURST) + 1;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK   = {ADDR_WIDTH{1'b1}} << LB;
  localparam logic [31:0]           MAX_BURST_W  = MAX_BURST;
  localparam logic [31:0]           FIFO_DEPTH_W = FIFO_DEPTH;
  localparam logic [BW-1:0]         ONE_B        = 1;

  typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           remaining;
  logic [BW-1:0]         blen_q;
  logic [BW-1:0]         beat_cnt;

  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;
  logic [PW:0]           count;
  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [DATA_WIDTH:0]   head;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  last_beat;
  logic                  push_last;

  logic [31:0]           to_4k;
  logic [31:0]           blen_calc;
  logic [31:0]           free_slots;
  logic [ADDR_WIDTH-1:0] burst_bytes;

  assign arsize  = 3'(LB);
  assign arburst = 2'b01;
  assign araddr  = addr_q;

  // FIFO status; the extra pointer bit separates full from empty
  assign count  = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head   = mem[rd_ptr[PW-1:0]];

  assign rready  = rstn && (state == DATA) && !full;
  assign m_valid = rstn && !empty;
  assign m_data  = head[DATA_WIDTH-1:0];
  assign m_last  = m_valid && head[DATA_WIDTH];

  assign push      = rvalid && rready;
  assign pop       = m_valid && m_ready;
  assign last_beat = (beat_cnt == ONE_B);
  // remaining is already reduced by the current burst at AR time
  assign push_last = last_beat && (remaining == 32'd0);

  assign burst_bytes = {{(ADDR_WIDTH-BW){1'b0}}, blen_q} << LB;

  // Next burst length: limited by what is left, MAX_BURST and the 4 KB page
  always_comb begin
    to_4k      = (32'd4096 - 32'(addr_q[11:0])) >> LB;
    free_slots = FIFO_DEPTH_W - 32'(count);
    blen_calc  = remaining;
    if (blen_calc > MAX_BURST_W) blen_calc = MAX_BURST_W;
    if (blen_calc > to_4k)       blen_calc = to_4k;
  end

  // Transfer control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_rlast <= 1'b0;
      arvalid   <= 1'b0;
      remaining <= '0;
      beat_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q    <= src_addr & ALIGN_MASK;
            remaining <= num_beats;
            err_rlast <= 1'b0;
            if (num_beats == 32'd0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          // Only ask for a burst the FIFO is guaranteed to absorb
          if (free_slots >= blen_calc) begin
            blen_q  <= blen_calc[BW-1:0];
            arlen   <= 8'(blen_calc - 32'd1);
            arvalid <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid   <= 1'b0;
            addr_q    <= addr_q + burst_bytes;
            remaining <= remaining - 32'(blen_q);
            beat_cnt  <= blen_q;
            state     <= DATA;
          end
        end
        DATA: begin
          // Beat count, not rlast, ends the burst; rlast is only audited
          if (push) begin
            beat_cnt <= beat_cnt - ONE_B;
            if (rlast != last_beat) err_rlast <= 1'b1;
            if (last_beat) state <= (remaining != 32'd0) ? CALC : DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head[DATA_WIDTH]) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers wrap naturally through the extra MSB
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage: data plus a transfer-last tag per entry
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= {push_last, rdata};
  end

endmodule

// File: tb/tb_dma_read_engine.sv
// Scoreboard bench for dma_read_engine: main process queues expected ARs and
// stream beats, an AXI slave model answers bursts, monitors pop and compare.
module tb_dma_read_engine;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [63:0]  src_addr = '0;
  logic [31:0]  num_beats = '0;
  logic         busy, done, err_rlast;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [127:0] rdata = '0;
  logic         rlast = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [127:0] m_data;
  logic         m_last;

  dma_read_engine #(
    .ADDR_WIDTH(64), .DATA_WIDTH(128), .MAX_BURST(16), .FIFO_DEPTH(32)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .src_addr(src_addr),
    .num_beats(num_beats), .busy(busy), .done(done), .err_rlast(err_rlast),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rlast(rlast), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [127:0] data; logic last; } beat_t;

  ar_t   exp_ar[$];
  beat_t exp_beat[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int ar_count   = 0;
  int pop_count  = 0;
  int done_count = 0;
  bit kill       = 1'b0;
  bit inject     = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory contents seen by the slave model: each beat tagged with its address
  function automatic logic [127:0] beat_data(input logic [63:0] a);
    return {~a, a};
  endfunction

  task automatic push_ar(input logic [63:0] a, input logic [7:0] len);
    ar_t e;
    e.addr = a;
    e.len  = len;
    exp_ar.push_back(e);
  endtask

  task automatic expect_xfer(input logic [63:0] a, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = beat_data(a + 64'(i) * 64'd16);
      b.last = (i == n - 1);
      exp_beat.push_back(b);
    end
  endtask

  task automatic do_start(input logic [63:0] a, input logic [31:0] n);
    @(posedge clk); #1;
    start = 1'b1; src_addr = a; num_beats = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int k = 0;
    while (done_count < target && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #2;
    check(name, 128'(done_count), 128'(target));
  endtask

  // AR monitor
  always @(negedge clk) begin
    ar_t e;
    if (arvalid && arready) begin
      ar_count++;
      if (exp_ar.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ar_unexpected: got araddr %0h arlen %0d, expected no AR", araddr, arlen);
      end else begin
        e = exp_ar.pop_front();
        check("araddr", araddr, e.addr);
        check("arlen", arlen, e.len);
        check("arsize", arsize, 3'd4);
        check("arburst", arburst, 2'b01);
      end
    end
  end

  // Output stream monitor
  always @(negedge clk) begin
    beat_t b;
    if (m_valid && m_ready) begin
      pop_count++;
      if (exp_beat.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL beat_unexpected: got m_data %0h, expected no beat", m_data);
      end else begin
        b = exp_beat.pop_front();
        check("m_data", m_data, b.data);
        check("m_last", m_last, b.last);
      end
    end
  end

  // Done pulse counter
  always @(negedge clk) begin
    if (done) done_count++;
  end

  // Slave R channel: one burst, stalls on rready, parks on kill
  task automatic run_burst(input logic [63:0] a, input logic [7:0] len);
    int  i = 0;
    logic hs;
    while (i <= int'(len)) begin
      if (kill) begin
        rvalid = 1'b1;
        while (kill) begin
          @(posedge clk); #1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        return;
      end
      rvalid = 1'b1;
      rdata  = beat_data(a + 64'(i) * 64'd16);
      rlast  = (i == int'(len)) || (inject && i == 2);
      @(negedge clk);
      hs = rready;
      @(posedge clk); #1;
      if (hs) i++;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  // Slave AR channel: holds arready low two cycles to exercise AR stability
  initial begin : slave
    logic [63:0] a;
    logic [7:0]  l;
    forever begin
      @(posedge clk); #1;
      if (arvalid && !kill) begin
        a = araddr;
        l = arlen;
        repeat (2) begin
          @(negedge clk);
          check("ar_hold_addr", araddr, a);
          check("ar_hold_valid", arvalid, 1'b1);
          @(posedge clk); #1;
        end
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        run_burst(a, l);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base_ar;
    int base_pop;
    int k;

    // Reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err_rlast, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_arsize", arsize, 3'd4);
    check("rst_arburst", arburst, 2'b01);
    @(posedge clk); #1;
    rstn = 1'b1;
    m_ready = 1'b1;

    // 40 beats from 0x1000, with a start issued mid-transfer that must be ignored
    push_ar(64'h1000, 8'd15);
    push_ar(64'h1100, 8'd15);
    push_ar(64'h1200, 8'd7);
    expect_xfer(64'h1000, 40);
    do_start(64'h1000, 32'd40);
    @(negedge clk);
    check("t1_busy", busy, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; src_addr = 64'h9000; num_beats = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1, "t1_done");
    repeat (3) @(posedge clk);
    #1;
    check("t1_beats_left", 128'(exp_beat.size()), 128'd0);
    check("t1_ars_left", 128'(exp_ar.size()), 128'd0);
    check("t1_busy_end", busy, 1'b0);

    // 4 KB boundary split
    push_ar(64'h0F80, 8'd7);
    push_ar(64'h1000, 8'd11);
    expect_xfer(64'h0F80, 20);
    do_start(64'h0F80, 32'd20);
    wait_done(2, "t2_done");
    repeat (3) @(posedge clk);
    #1;
    check("t2_beats_left", 128'(exp_beat.size()), 128'd0);
    check("t2_ars_left", 128'(exp_ar.size()), 128'd0);

    // Zero-length transfer
    base_ar = ar_count;
    do_start(64'h7000, 32'd0);
    @(negedge clk);
    check("t3_done_pulse", done, 1'b1);
    check("t3_busy", busy, 1'b0);
    @(negedge clk);
    check("t3_done_drop", done, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("t3_no_ar", 128'(ar_count - base_ar), 128'd0);
    check("t3_done_count", 128'(done_count), 128'd3);

    // Credit stall with a blocked consumer
    m_ready = 1'b0;
    base_ar = ar_count;
    push_ar(64'h2000, 8'd15);
    push_ar(64'h2100, 8'd15);
    push_ar(64'h2200, 8'd15);
    push_ar(64'h2300, 8'd15);
    expect_xfer(64'h2000, 64);
    do_start(64'h2000, 32'd64);
    repeat (100) @(posedge clk);
    #1;
    check("t4_two_ars", 128'(ar_count - base_ar), 128'd2);
    check("t4_m_valid", m_valid, 1'b1);
    base_pop = pop_count;
    m_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    m_ready = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("t4_pops15", 128'(pop_count - base_pop), 128'd15);
    check("t4_still_two_ars", 128'(ar_count - base_ar), 128'd2);
    m_ready = 1'b1;
    wait_done(4, "t4_done");
    repeat (3) @(posedge clk);
    #1;
    check("t4_four_ars", 128'(ar_count - base_ar), 128'd4);
    check("t4_beats_left", 128'(exp_beat.size()), 128'd0);

    // Early rlast on beat 3 of a 16-beat burst
    inject = 1'b1;
    push_ar(64'h4000, 8'd15);
    expect_xfer(64'h4000, 16);
    do_start(64'h4000, 32'd16);
    wait_done(5, "t5_done");
    inject = 1'b0;
    #1;
    check("t5_err_rlast", err_rlast, 1'b1);
    check("t5_beats_left", 128'(exp_beat.size()), 128'd0);

    // Reset during the second burst, then a short clean transfer
    push_ar(64'h5000, 8'd15);
    push_ar(64'h5100, 8'd15);
    expect_xfer(64'h5000, 32);
    do_start(64'h5000, 32'd32);
    @(negedge clk);
    check("t6_err_cleared", err_rlast, 1'b0);
    base_pop = pop_count;
    k = 0;
    while (pop_count < base_pop + 20 && k < 500) begin
      @(posedge clk);
      k++;
    end
    check("t6_progress", 128'(pop_count >= base_pop + 20), 128'd1);
    @(posedge clk); #1;
    rstn = 1'b0;
    kill = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_done", done, 1'b0);
    check("t6_rst_arvalid", arvalid, 1'b0);
    check("t6_rst_rready", rready, 1'b0);
    check("t6_rst_m_valid", m_valid, 1'b0);
    check("t6_rst_m_last", m_last, 1'b0);
    exp_ar.delete();
    exp_beat.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_stale_rready", rready, 1'b0);
    end
    @(posedge clk); #1;
    kill = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_done", 128'(done_count), 128'd5);
    push_ar(64'h3000, 8'd3);
    expect_xfer(64'h3000, 4);
    do_start(64'h3007, 32'd4);
    wait_done(6, "t6_done");
    repeat (3) @(posedge clk);
    #1;
    check("t6_err_clean", err_rlast, 1'b0);
    check("t6_beats_left", 128'(exp_beat.size()), 128'd0);
    check("t6_ars_left", 128'(exp_ar.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
